// File: rtl/sum_squares_pkg.sv
// -----------------------------------------------------------------------------
// sum_squares_pkg
// Width helpers shared by the windowed mean-square engine and by whoever
// instantiates the downstream sqrt block.
//   sq_width(in_width)          : width of |x|^2, 2*in_width-1 bits
//   acc_width(in_width, log2_n) : width of a full-window sum, never overflows
//   out_width(in_width)         : mean-square word width, equals sqrt WIDTH
// -----------------------------------------------------------------------------
package sum_squares_pkg;

  // The largest square is (2^(W-1))^2 = 2^(2W-2), which needs 2W-1 bits.
  function automatic int sq_width(input int in_width);
    return 2 * in_width - 1;
  endfunction

  // The sum of 2^log2_n squares needs log2_n extra bits on top of sq_width.
  function automatic int acc_width(input int in_width, input int log2_n);
    return 2 * in_width - 1 + log2_n;
  endfunction

  function automatic int out_width(input int in_width);
    return 2 * in_width;
  endfunction

  // Default configuration: 16-bit samples feed a 32-bit sqrt.
  localparam int DEFAULT_IN_WIDTH  = 16;
  localparam int DEFAULT_OUT_WIDTH = 2 * DEFAULT_IN_WIDTH;

endpackage

// File: rtl/sum_squares_abs_square.sv
// -----------------------------------------------------------------------------
// abs_square
// Two-stage pipeline: stage 1 registers |in_data|, stage 2 registers its
// square. A valid bit travels alongside the data; flush drops everything in
// flight, including a sample presented in the same cycle.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : synchronous discard of all in-flight samples
//   in_valid    : in_data holds a sample this cycle
//   in_data     : signed sample (two's complement)
//   out_valid   : out_sq holds the square of a sample accepted 2 cycles ago
//   out_sq      : unsigned square, sq_width(IN_WIDTH) bits
// -----------------------------------------------------------------------------
module abs_square
  import sum_squares_pkg::*;
#(
  parameter int IN_WIDTH = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flush,
  input  logic                               in_valid,
  input  logic signed [IN_WIDTH-1:0]         in_data,
  output logic                               out_valid,
  output logic [sq_width(IN_WIDTH)-1:0]      out_sq
);

  localparam int SQW = sq_width(IN_WIDTH);

  logic [IN_WIDTH-1:0] raw;
  logic [IN_WIDTH-1:0] abs_c;
  logic [IN_WIDTH-1:0] abs_r;
  logic                abs_valid_r;
  logic [SQW-1:0]      abs_ext;
  logic [SQW-1:0]      sq_c;

  // Negating the most negative value yields the same bit pattern 100..0,
  // which read as unsigned is exactly 2^(IN_WIDTH-1), the correct magnitude.
  always_comb begin
    raw   = in_data;
    abs_c = raw[IN_WIDTH-1] ? (~raw + IN_WIDTH'(1)) : raw;
  end

  // The square always fits in SQW bits, so a SQW-bit multiply loses nothing.
  always_comb begin
    abs_ext = SQW'(abs_r);
    sq_c    = abs_ext * abs_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abs_r       <= '0;
      abs_valid_r <= 1'b0;
      out_sq      <= '0;
      out_valid   <= 1'b0;
    end else begin
      abs_r       <= abs_c;
      abs_valid_r <= in_valid & ~flush;
      out_sq      <= sq_c;
      out_valid   <= abs_valid_r & ~flush;
    end
  end

endmodule

// File: rtl/sum_squares.sv
// -----------------------------------------------------------------------------
// sum_squares
// Windowed mean-square engine feeding the sqrt pipeline for RMS measurement.
// Each window of 2^LOG2_N accepted samples produces one mean square
// (sum of squares >> LOG2_N, truncated) on source with a one-cycle strobe.
//
// Valid semantics: there is no backpressure. A sample is accepted in every
// cycle where sink_valid=1 and clr=0; source_valid is a one-cycle strobe that
// marks the cycle in which source took a new value. source holds otherwise.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   clr          : synchronous abort of the current window and in-flight data
//   sink         : signed sample, IN_WIDTH bits
//   sink_valid   : sink holds a sample this cycle
//   source       : mean square of last completed window, 2*IN_WIDTH bits
//   source_valid : source updated this cycle
// Latency: Nth sample in cycle t -> source/source_valid visible in cycle t+3.
// -----------------------------------------------------------------------------
module sum_squares
  import sum_squares_pkg::*;
#(
  parameter int IN_WIDTH = 16,
  parameter int LOG2_N   = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr,
  input  logic signed [IN_WIDTH-1:0]     sink,
  input  logic                           sink_valid,
  output logic [out_width(IN_WIDTH)-1:0] source,
  output logic                           source_valid
);

  localparam int SQW  = sq_width(IN_WIDTH);
  localparam int ACCW = acc_width(IN_WIDTH, LOG2_N);
  localparam int OUTW = out_width(IN_WIDTH);

  logic            sq_valid;
  logic [SQW-1:0]  sq;
  logic [ACCW-1:0] acc;
  logic [ACCW-1:0] sum_c;
  logic [LOG2_N-1:0] cnt;
  logic            last_c;

  // clr doubles as the pipeline flush, so a sample presented alongside clr
  // and anything already in stages 1-2 never reaches the accumulator.
  abs_square #(
    .IN_WIDTH (IN_WIDTH)
  ) u_abs_square (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (clr),
    .in_valid  (sink_valid),
    .in_data   (sink),
    .out_valid (sq_valid),
    .out_sq    (sq)
  );

  // Sum including the incoming square, so the closing sample of a window is
  // folded into the result on the same edge that restarts the accumulator.
  always_comb begin
    sum_c  = acc + ACCW'(sq);
    last_c = (cnt == '1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc          <= '0;
      cnt          <= '0;
      source       <= '0;
      source_valid <= 1'b0;
    end else begin
      source_valid <= 1'b0;
      if (clr) begin
        // Also suppresses a completion that would have landed on this edge.
        acc <= '0;
        cnt <= '0;
      end else if (sq_valid) begin
        if (last_c) begin
          // Upper ACCW-OUTW bits of the shifted sum are always zero.
          source       <= OUTW'(sum_c >> LOG2_N);
          source_valid <= 1'b1;
          acc          <= '0;
          cnt          <= '0;
        end else begin
          acc <= sum_c;
          cnt <= cnt + LOG2_N'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sum_squares.sv
// -----------------------------------------------------------------------------
// tb_sum_squares
// Bench for sum_squares with IN_WIDTH=16, LOG2_N=2 (N=4). The reference model
// keeps the accepted samples in a pending queue tagged with their drive cycle,
// retires each one three cycles later into a running window sum, and on every
// fourth retired sample pushes sum/4 and the strobe cycle into the expected
// queues. A negedge monitor pops and compares whenever source_valid is seen.
// -----------------------------------------------------------------------------
module tb_sum_squares;

  localparam int W  = 16;
  localparam int L  = 2;
  localparam int N  = 1 << L;
  localparam int OW = 2 * W;

  logic                clk;
  logic                rst_n;
  logic                clr;
  logic signed [W-1:0] sink;
  logic                sink_valid;
  logic [OW-1:0]       source;
  logic                source_valid;

  sum_squares #(
    .IN_WIDTH (W),
    .LOG2_N   (L)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .sink         (sink),
    .sink_valid   (sink_valid),
    .source       (source),
    .source_valid (source_valid)
  );

  // ---------------- clock / reset / cycle counter ----------------
  int cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model and scoreboard ----------------
  logic [OW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  int            pend_s[$];
  int            pend_d[$];
  longint        win_sum;
  int            win_cnt;
  logic [OW-1:0] hold;
  int            errors;
  int            checks;

  // A sample driven in cycle d updates the outputs seen in cycle d+3.
  task automatic retire(input int c);
    int s;
    while (pend_d.size() > 0 && pend_d[0] <= c - 3) begin
      s = pend_s.pop_front();
      void'(pend_d.pop_front());
      win_sum = win_sum + longint'(s) * longint'(s);
      win_cnt = win_cnt + 1;
      if (win_cnt == N) begin
        hold = OW'(win_sum >> L);
        exp_q.push_back(hold);
        exp_cyc_q.push_back(c);
        win_sum = 0;
        win_cnt = 0;
      end
    end
  endtask

  task automatic model_clear();
    pend_s.delete();
    pend_d.delete();
    win_sum = 0;
    win_cnt = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input int s, input bit c_clr);
    int c;
    @(posedge clk);
    #1;
    c = cyc;
    retire(c);
    sink_valid = v;
    sink       = W'(s);
    clr        = c_clr;
    if (rst_n) begin
      if (c_clr) model_clear();
      else if (v) begin
        pend_s.push_back(s);
        pend_d.push_back(c);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    retire(cyc);
    #1;
    sink_valid = 1'b0;
    clr        = 1'b0;
    rst_n      = 1'b0;
    model_clear();
    exp_q.delete();
    exp_cyc_q.delete();
    hold = '0;
    #1;
    checks++;
    if (source !== '0) begin
      errors++;
      $display("FAIL async_reset_source actual=%0d required=0", source);
    end
    checks++;
    if (source_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_valid actual=%b required=0", source_valid);
    end
    #1;
    rst_n = 1'b1;
  endtask

  function automatic int rnd_sample();
    logic signed [W-1:0] t;
    t = W'($urandom);
    return int'(t);
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [OW-1:0] v;
    int            ec;
    if (source_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe cycle=%0d source=%0d required=no strobe",
                 cyc, source);
      end else begin
        v  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        checks++;
        if (source !== v) begin
          errors++;
          $display("FAIL window_value cycle=%0d actual=%0d required=%0d", cyc, source, v);
        end
        checks++;
        if (ec != cyc) begin
          errors++;
          $display("FAIL strobe_cycle actual=%0d required=%0d", cyc, ec);
        end
      end
    end else if (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_strobe cycle=%0d required_value=%0d", cyc, exp_q[0]);
      void'(exp_q.pop_front());
      void'(exp_cyc_q.pop_front());
    end
    checks++;
    if (source !== hold) begin
      errors++;
      $display("FAIL source_hold cycle=%0d actual=%0d required=%0d", cyc, source, hold);
    end
  end

  // ---------------- stimulus ----------------
  int seq_a[4] = '{3, -4, 5, -6};
  int seq_b[4] = '{1, 1, 1, 2};

  initial begin
    cyc        = 0;
    errors     = 0;
    checks     = 0;
    hold       = '0;
    win_sum    = 0;
    win_cnt    = 0;
    rst_n      = 1'b0;
    clr        = 1'b0;
    sink       = '0;
    sink_valid = 1'b0;

    // Reset held with random traffic: outputs must stay zero.
    for (int i = 0; i < 6; i++)
      drive(1'($urandom_range(0, 1)), rnd_sample(), 1'($urandom_range(0, 1)));
    sink_valid = 1'b0;
    clr        = 1'b0;
    rst_n      = 1'b1;
    idle(3);

    // Back-to-back windows.
    for (int i = 0; i < 4; i++) drive(1'b1, seq_a[i], 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, seq_b[i], 1'b0);
    idle(5);

    // Extremes.
    for (int i = 0; i < 4; i++) drive(1'b1, -32768, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 32767, 1'b0);
    idle(5);

    // Gapped input.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, seq_a[i], 1'b0);
      idle($urandom_range(0, 3));
    end
    idle(5);

    // Abort mid-window, then a fresh window.
    drive(1'b1, 100, 1'b0);
    drive(1'b1, 100, 1'b0);
    drive(1'b0, 0, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 2, 1'b0);
    idle(5);

    // clr wins over a same-cycle sample.
    drive(1'b1, 1000, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 2, 1'b0);
    idle(5);

    // clr on the edge where a completion is in flight.
    for (int i = 0; i < 4; i++) drive(1'b1, 7, 1'b0);
    idle(1);
    drive(1'b0, 0, 1'b1);
    idle(5);

    // Async reset mid-window.
    drive(1'b1, 50, 1'b0);
    drive(1'b1, 50, 1'b0);
    pulse_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, 4, 1'b0);
    idle(5);

    // Random traffic with occasional clr and reset.
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3)       drive(1'($urandom_range(0, 1)), rnd_sample(), 1'b1);
      else if (r < 4)  pulse_reset();
      else if (r < 75) drive(1'b1, rnd_sample(), 1'b0);
      else             drive(1'b0, rnd_sample(), 1'b0);
    end
    idle(8);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected actual=%0d pending required=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
